// File: rtl/dma_copy_pkg.sv
// Shared definitions for the dma_copy engine: register offsets, status bits,
// FSM state encoding and the byte-strobe merge helper.
package dma_copy_pkg;

  localparam logic [3:0] REG_SRC  = 4'h0;
  localparam logic [3:0] REG_DST  = 4'h4;
  localparam logic [3:0] REG_LEN  = 4'h8;
  localparam logic [3:0] REG_CTRL = 4'hC;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_ERR  = 2;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_CLEAR = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_GAP,
    ST_WR,
    ST_WR_GAP,
    ST_FIN
  } state_e;

  // Replace only the bytes selected by strb.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dma_copy_regs.sv
// Register window for dma_copy: address decode, one-cycle cfg_ready strobe,
// SRC/DST/LEN storage and the start/clear pulses toward the engine FSM.
module dma_copy_regs
  import dma_copy_pkg::*;
#(
  parameter logic [31:0] ADDR     = 32'h4000_1000,
  parameter int unsigned LEN_BITS = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cfg_valid,
  input  logic [31:0]         cfg_addr,
  input  logic [31:0]         cfg_wdata,
  input  logic [3:0]          cfg_wstrb,
  input  logic                busy,
  input  logic                done,
  input  logic                err,
  output logic                cfg_sel,
  output logic                cfg_ready,
  output logic [31:0]         cfg_rdata,
  output logic [31:0]         src,
  output logic [31:0]         dst,
  output logic [LEN_BITS-1:0] len,
  output logic                start_c,
  output logic                clear_c
);

  logic                ready_q, ready_d;
  logic                ack_q, ack_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         src_q, src_d;
  logic [31:0]         dst_q, dst_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic                wr_en_c;
  logic [31:0]         rd_mux_c;

  assign cfg_sel   = cfg_valid && (cfg_addr[31:4] == ADDR[31:4]);
  assign cfg_ready = ready_q;
  assign cfg_rdata = rdata_q;
  assign src       = src_q;
  assign dst       = dst_q;
  assign len       = len_q;

  // Writes land on the edge that closes the cfg_ready cycle.
  assign wr_en_c = ready_q && cfg_sel && (cfg_wstrb != 4'b0000);
  assign start_c = wr_en_c && (cfg_addr[3:0] == REG_CTRL) && cfg_wstrb[0] && cfg_wdata[CTRL_START];
  assign clear_c = wr_en_c && (cfg_addr[3:0] == REG_CTRL) && cfg_wstrb[0] && cfg_wdata[CTRL_CLEAR];

  always_comb begin
    rd_mux_c = '0;
    case (cfg_addr[3:0])
      REG_SRC:  rd_mux_c = src_q;
      REG_DST:  rd_mux_c = dst_q;
      REG_LEN:  rd_mux_c = 32'(len_q);
      REG_CTRL: begin
        rd_mux_c[STAT_BUSY] = busy;
        rd_mux_c[STAT_DONE] = done;
        rd_mux_c[STAT_ERR]  = err;
      end
      default: rd_mux_c = '0;
    endcase
  end

  always_comb begin
    // ack_q blocks a second strobe until the requester drops cfg_valid.
    ready_d = cfg_sel && !ready_q && !ack_q;
    ack_d   = cfg_valid && (ack_q || ready_q);
    rdata_d = ready_d ? rd_mux_c : '0;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    if (wr_en_c && !busy) begin
      case (cfg_addr[3:0])
        REG_SRC: src_d = apply_strb(src_q, cfg_wdata, cfg_wstrb);
        REG_DST: dst_d = apply_strb(dst_q, cfg_wdata, cfg_wstrb);
        REG_LEN: len_d = LEN_BITS'(apply_strb(32'(len_q), cfg_wdata, cfg_wstrb));
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
    end else begin
      ready_q <= ready_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: rtl/dma_copy.sv
// Word-granular memory-to-memory copy engine: register window plus a
// read/gap/write/gap bus initiator. Optional watchdog under DMA_TIMEOUT_EN.
module dma_copy
  import dma_copy_pkg::*;
#(
  parameter logic [31:0] ADDR           = 32'h4000_1000,
  parameter int unsigned LEN_BITS       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cfg_valid,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic [3:0]  cfg_wstrb,
  output logic        cfg_sel,
  output logic        cfg_ready,
  output logic [31:0] cfg_rdata,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        irq
);

  logic [31:0]         src, dst;
  logic [LEN_BITS-1:0] len;
  logic                start_c, clear_c, tmo_c, busy;

  state_e              state_q, state_d;
  logic [31:0]         cur_src_q, cur_src_d;
  logic [31:0]         cur_dst_q, cur_dst_d;
  logic [31:0]         data_q, data_d;
  logic [LEN_BITS-1:0] rem_q, rem_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                m_valid_q, m_valid_d;
  logic [31:0]         m_addr_q, m_addr_d;
  logic [31:0]         m_wdata_q, m_wdata_d;
  logic [3:0]          m_wstrb_q, m_wstrb_d;

  assign busy    = (state_q != ST_IDLE);
  assign m_valid = m_valid_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;
  assign irq     = done_q;

  dma_copy_regs #(
    .ADDR     (ADDR),
    .LEN_BITS (LEN_BITS)
  ) u_regs (
    .clk       (clk),
    .resetn    (resetn),
    .cfg_valid (cfg_valid),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_wstrb (cfg_wstrb),
    .busy      (busy),
    .done      (done_q),
    .err       (err_q),
    .cfg_sel   (cfg_sel),
    .cfg_ready (cfg_ready),
    .cfg_rdata (cfg_rdata),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .start_c   (start_c),
    .clear_c   (clear_c)
  );

`ifdef DMA_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts cycles spent waiting in one bus state; any state change restarts it.
  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q == ST_RD || state_q == ST_WR) && (state_d == state_q)) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  assign tmo_c = (state_q == ST_RD || state_q == ST_WR) && !m_ready &&
                 (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!resetn) tmo_cnt_q <= '0;
    else         tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_c = 1'b0;

  // The watchdog limit is only consumed by the timeout build.
  if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
  end
`endif

  // Clear is applied before any FSM event so start-with-clear and FIN behave.
  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    rem_d     = rem_q;
    data_d    = data_q;
    done_d    = done_q;
    err_d     = err_q;
    if (clear_c) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          if ((src[1:0] != 2'b00) || (dst[1:0] != 2'b00)) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if (len == '0) begin
            state_d = ST_FIN;
          end else begin
            cur_src_d = src;
            cur_dst_d = dst;
            rem_d     = len;
            state_d   = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (m_ready) begin
          data_d  = m_rdata;
          state_d = ST_RD_GAP;
        end else if (tmo_c) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RD_GAP: state_d = ST_WR;
      ST_WR: begin
        if (m_ready) begin
          cur_src_d = cur_src_q + 32'd4;
          cur_dst_d = cur_dst_q + 32'd4;
          rem_d     = rem_q - LEN_BITS'(1);
          state_d   = ST_WR_GAP;
        end else if (tmo_c) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR_GAP: state_d = (rem_q != '0) ? ST_RD : ST_FIN;
      ST_FIN: begin
        if (!clear_c) done_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs decode the next state so they are registered yet state-aligned.
  always_comb begin
    m_valid_d = (state_d == ST_RD) || (state_d == ST_WR);
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = 4'b0000;
    if (state_d == ST_RD) begin
      m_addr_d = cur_src_d;
    end else if (state_d == ST_WR) begin
      m_addr_d  = cur_dst_d;
      m_wdata_d = data_d;
      m_wstrb_d = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      data_q    <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      data_q    <= data_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      err_q     <= err_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
    end
  end

endmodule
